// File: rtl/flit_source.sv
// flit_source: synthetic traffic injector for one router input port.
// Emits fixed-length packets (head flit carrying an LFSR-derived destination,
// then body flits carrying their index) over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   enable     permission to start a new packet (sampled only when idle)
//   out_valid  flit on out_data is offered
//   out_data   {head flag, dest or payload}
//   out_last   offered flit is the last of its packet
//   out_ready  downstream accepts on out_valid && out_ready
//   pkt_count  completed packets, wraps at 16 bits
//   busy       high while a packet or its trailing gap is in progress
module flit_source #(
  parameter int unsigned SEED      = 5,
  parameter int unsigned SIZE      = 8,
  parameter int unsigned PKT_FLITS = 4,
  parameter int unsigned GAP       = 2,
  parameter int unsigned MAX_PKTS  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [15:0]     pkt_count,
  output logic            busy
);

  localparam int unsigned DEST_BITS = SIZE - 1;
  localparam int unsigned IDX_W     = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam int unsigned GAP_W     = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [15:0] SEED_INIT = (SEED == 0) ? 16'd1 : 16'(SEED);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_FLITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_BODY,
    S_GAP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic              out_valid_q, out_valid_d;
  logic [SIZE-1:0]   out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              complete;

  // Next-state, LFSR, counters and the registered output image of the next state
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    pkt_count_d = pkt_count_q;
    complete    = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_last_d  = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_HEAD;
      end
      S_HEAD: begin
        if (out_ready) begin
          // Destination advances once per accepted head flit
          lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'd0);
          if (PKT_FLITS > 1) begin
            state_d = S_BODY;
            idx_d   = IDX_W'(1);
          end else begin
            complete = 1'b1;
          end
        end
      end
      S_BODY: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) complete = 1'b1;
          else                   idx_d    = idx_q + IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q <= GAP_W'(1)) state_d = S_IDLE;
        else                    gap_d   = gap_q - GAP_W'(1);
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Packet completion: count, then stop, pause or return to idle
    if (complete) begin
      pkt_count_d = pkt_count_q + 16'd1;
      idx_d       = '0;
      if ((MAX_PKTS != 0) && (pkt_count_d == 16'(MAX_PKTS))) begin
        state_d = S_DONE;
      end else if (GAP > 0) begin
        state_d = S_GAP;
        gap_d   = GAP_W'(GAP);
      end else begin
        state_d = S_IDLE;
      end
    end

    // Outputs depend only on the next state, so they hold while stalled
    case (state_d)
      S_HEAD: begin
        out_valid_d = 1'b1;
        out_data_d  = {1'b1, lfsr_d[DEST_BITS-1:0]};
        out_last_d  = (PKT_FLITS == 1);
        busy_d      = 1'b1;
      end
      S_BODY: begin
        out_valid_d = 1'b1;
        out_data_d  = {1'b0, DEST_BITS'(idx_d)};
        out_last_d  = (idx_d == IDX_LAST);
        busy_d      = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_INIT;
      idx_q       <= '0;
      gap_q       <= '0;
      pkt_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      pkt_count_q <= pkt_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign pkt_count = pkt_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_flit_source.sv
// Directed bench for flit_source: default packet stream, backpressure,
// enable drop, async reset mid-packet, MAX_PKTS stop, and 1-flit/no-gap packets.
module tb_flit_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        a_reset, a_enable, a_ready, a_valid, a_last, a_busy;
  logic [7:0]  a_data;
  logic [15:0] a_cnt;
  // MAX_PKTS=2 instance
  logic        m_reset, m_enable, m_ready, m_valid, m_last, m_busy;
  logic [7:0]  m_data;
  logic [15:0] m_cnt;
  // PKT_FLITS=1, GAP=0 instance
  logic        e_reset, e_enable, e_ready, e_valid, e_last, e_busy;
  logic [7:0]  e_data;
  logic [15:0] e_cnt;

  flit_source dut_a (
    .clk(clk), .reset(a_reset), .enable(a_enable), .out_valid(a_valid),
    .out_data(a_data), .out_last(a_last), .out_ready(a_ready),
    .pkt_count(a_cnt), .busy(a_busy)
  );

  flit_source #(.MAX_PKTS(2)) dut_m (
    .clk(clk), .reset(m_reset), .enable(m_enable), .out_valid(m_valid),
    .out_data(m_data), .out_last(m_last), .out_ready(m_ready),
    .pkt_count(m_cnt), .busy(m_busy)
  );

  flit_source #(.PKT_FLITS(1), .GAP(0)) dut_e (
    .clk(clk), .reset(e_reset), .enable(e_enable), .out_valid(e_valid),
    .out_data(e_data), .out_last(e_last), .out_ready(e_ready),
    .pkt_count(e_cnt), .busy(e_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the default instance; data/last only meaningful while valid
  task automatic exp_a(input string tag, input logic v, input logic [7:0] d,
                       input logic l, input logic b, input logic [15:0] pc);
    chk({tag, ".valid"}, 32'(a_valid), 32'(v));
    if (v) begin
      chk({tag, ".data"}, 32'(a_data), 32'(d));
      chk({tag, ".last"}, 32'(a_last), 32'(l));
    end
    chk({tag, ".busy"}, 32'(a_busy), 32'(b));
    chk({tag, ".cnt"},  32'(a_cnt),  32'(pc));
  endtask

  task automatic exp_e(input string tag, input logic v, input logic [7:0] d,
                       input logic [15:0] pc);
    chk({tag, ".valid"}, 32'(e_valid), 32'(v));
    if (v) begin
      chk({tag, ".data"}, 32'(e_data), 32'(d));
      chk({tag, ".last"}, 32'(e_last), 32'(1'b1));
    end
    chk({tag, ".cnt"}, 32'(e_cnt), 32'(pc));
  endtask

  initial begin
    int acc;
    int late;
    a_reset = 1'b0; a_enable = 1'b0; a_ready = 1'b0;
    m_reset = 1'b0; m_enable = 1'b0; m_ready = 1'b0;
    e_reset = 1'b0; e_enable = 1'b0; e_ready = 1'b0;
    #2;
    chk("rst.valid", 32'(a_valid), 32'd0);
    chk("rst.data",  32'(a_data),  32'd0);
    chk("rst.busy",  32'(a_busy),  32'd0);
    chk("rst.cnt",   32'(a_cnt),   32'd0);

    // Default stream, ready always high
    a_enable = 1'b1; a_ready = 1'b1;
    tick(); a_reset = 1'b1;
    tick(); exp_a("t1.f0", 1, 8'h85, 0, 1, 16'd0);
    tick(); exp_a("t1.f1", 1, 8'h01, 0, 1, 16'd0);
    tick(); exp_a("t1.f2", 1, 8'h02, 0, 1, 16'd0);
    tick(); exp_a("t1.f3", 1, 8'h03, 1, 1, 16'd0);
    tick(); exp_a("t1.gap1", 0, 8'h00, 0, 1, 16'd1);
    tick(); exp_a("t1.gap2", 0, 8'h00, 0, 1, 16'd1);
    tick(); exp_a("t1.idle", 0, 8'h00, 0, 0, 16'd1);
    tick(); exp_a("t1.head2", 1, 8'h82, 0, 1, 16'd1);
    tick(); exp_a("t1.body1", 1, 8'h01, 0, 1, 16'd1);

    // Asynchronous reset in the middle of a body flit
    #2; a_reset = 1'b0;
    #1;
    chk("t5.valid", 32'(a_valid), 32'd0);
    chk("t5.cnt",   32'(a_cnt),   32'd0);
    chk("t5.busy",  32'(a_busy),  32'd0);

    // Backpressure on the first head after reset release
    a_ready = 1'b0;
    tick(); a_reset = 1'b1;
    tick(); exp_a("t2.head", 1, 8'h85, 0, 1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_a("t2.stall", 1, 8'h85, 0, 1, 16'd0);
    end
    a_ready = 1'b1;
    tick(); exp_a("t2.f1", 1, 8'h01, 0, 1, 16'd0);
    tick(); exp_a("t2.f2", 1, 8'h02, 0, 1, 16'd0);
    tick(); exp_a("t2.f3", 1, 8'h03, 1, 1, 16'd0);
    tick(); exp_a("t2.done", 0, 8'h00, 0, 1, 16'd1);

    // Enable dropped during body: packet finishes, then block waits idle
    tick(); exp_a("t3.gap", 0, 8'h00, 0, 1, 16'd1);
    tick(); exp_a("t3.idle", 0, 8'h00, 0, 0, 16'd1);
    tick(); exp_a("t3.head", 1, 8'h82, 0, 1, 16'd1);
    tick(); exp_a("t3.f1", 1, 8'h01, 0, 1, 16'd1);
    a_enable = 1'b0;
    tick(); exp_a("t3.f2", 1, 8'h02, 0, 1, 16'd1);
    tick(); exp_a("t3.f3", 1, 8'h03, 1, 1, 16'd1);
    tick(); exp_a("t3.end", 0, 8'h00, 0, 1, 16'd2);
    tick(); exp_a("t3.gap2", 0, 8'h00, 0, 1, 16'd2);
    for (int i = 0; i < 5; i++) begin
      tick(); exp_a("t3.wait", 0, 8'h00, 0, 0, 16'd2);
    end
    a_enable = 1'b1;
    tick(); exp_a("t3.resume", 1, 8'h81, 0, 1, 16'd2);

    // MAX_PKTS=2: exactly 8 accepted flits, then silent
    m_enable = 1'b1; m_ready = 1'b1;
    tick(); m_reset = 1'b1;
    acc = 0; late = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (m_valid) begin
        if (acc >= 8) late++;
        else acc++;
      end
    end
    chk("t4.flits", 32'(acc), 32'd8);
    chk("t4.late",  32'(late), 32'd0);
    chk("t4.cnt",   32'(m_cnt), 32'd2);
    chk("t4.busy",  32'(m_busy), 32'd0);
    chk("t4.valid", 32'(m_valid), 32'd0);

    // Single-flit packets, no gap: 2-cycle period following the LFSR
    e_enable = 1'b1; e_ready = 1'b1;
    tick(); e_reset = 1'b1;
    tick(); exp_e("t6.h0", 1, 8'h85, 16'd0);
    tick(); exp_e("t6.i0", 0, 8'h00, 16'd1);
    tick(); exp_e("t6.h1", 1, 8'h82, 16'd1);
    tick(); exp_e("t6.i1", 0, 8'h00, 16'd2);
    tick(); exp_e("t6.h2", 1, 8'h81, 16'd2);
    tick(); exp_e("t6.i2", 0, 8'h00, 16'd3);
    tick(); exp_e("t6.h3", 1, 8'h80, 16'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flit_source.md
# flit_source

Synthetic traffic injector that drives one input port of the router with fixed-length packets. Each packet is a head flit carrying a pseudo-random destination, followed by body flits. Flits are offered over a valid/ready handshake. The block sits directly upstream of a router port in the simulation bench. It replaces hand-written stimulus and exercises the routing-table lookup path with reproducible, seed-controlled destinations.

## Interface

- SEED, 5: initial LFSR value; 0 is replaced by 1.
- SIZE, 8: flit width in bits; 2..17. DEST_BITS = SIZE-1.
- PKT_FLITS, 4: flits per packet, including the head; ≥1.
- GAP, 2: idle cycles inserted after each packet; ≥0.
- MAX_PKTS, 0: packets to send before stopping; 0 means unlimited.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permission to start a new packet; sampled only in IDLE.
- out_valid  out  1  flit on out_data is offered.
- out_data  out  SIZE  flit: bit SIZE-1 = head flag, bits DEST_BITS-1:0 = dest or payload.
- out_last  out  1  offered flit is the last of its packet.
- out_ready  in  1  downstream accepts the flit when out_valid && out_ready at the edge.
- pkt_count  out  16  completed packets; wraps 65535→0.
- busy  out  1  high in HEAD, BODY or GAP.

## Operation

- Reset (reset=0, asynchronous):
  - state=IDLE; lfsr=SEED (or 1); pkt_count=0; flit index=0.
  - All outputs are 0 immediately, including mid-packet; the in-flight packet is abandoned and not resumed.
- LFSR: 16-bit Galois, right shift.
  - Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Steps only on head-flit acceptance.
  - dest = lfsr[DEST_BITS-1:0].
- States:
  - IDLE: out_valid=0. If enable=1 → HEAD.
  - HEAD: out_valid=1, out_data={1'b1, dest}, out_last=(PKT_FLITS==1).
    - On acceptance, if PKT_FLITS>1 → BODY with idx=1.
    - Otherwise the packet completes.
  - BODY: out_valid=1, out_data={1'b0, idx[DEST_BITS-1:0]}, out_last=(idx==PKT_FLITS-1).
    - On acceptance, idx increments.
    - On acceptance of the last flit, the packet completes.
  - Packet completion:
    - pkt_count increments.
    - If MAX_PKTS≠0 and the new count equals MAX_PKTS → DONE.
    - Else if GAP>0 → GAP with counter=GAP.
    - Else → IDLE.
  - GAP: out_valid=0; counter decrements each cycle; at 1 → IDLE. The state lasts exactly GAP cycles.
  - DONE: out_valid=0, busy=0. Terminal until reset.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable and out_valid stays high.
  - out_ready is ignored when out_valid=0.
  - enable has no effect outside IDLE; dropping it mid-packet does not abort the packet.
- pkt_count comparison with MAX_PKTS uses the 16-bit value. MAX_PKTS>65535 is unsupported.

## Timing

- All outputs are registered or decoded from state only. There is no combinational path from out_ready or enable to any output.
- First head flit: out_valid rises after the first rising edge where reset=1 and enable=1.
- With out_ready held at 1, a packet occupies PKT_FLITS consecutive cycles.
- Head-to-head period = PKT_FLITS+GAP+1 cycles. Defaults give 7.
- Each stall cycle (out_ready=0 with out_valid=1) extends the period by exactly 1.
- pkt_count and the DONE transition update on the edge that accepts the last flit.
- busy falls on entry to IDLE or DONE.

## Test plan

- Defaults, enable=1, out_ready=1 from reset release:
  - Flits are 0x85, 0x01, 0x02, 0x03 (last on 0x03).
  - Then 2 idle cycles + 1 IDLE cycle.
  - Next head is 0x82 (lfsr 0xB402).
  - pkt_count=1 after the 4th flit.
- Backpressure: out_ready=0 for 3 cycles while head 0x85 is offered.
  - out_valid stays 1 and out_data stays 0x85 throughout.
  - The packet completes 3 cycles later than in the unstalled case.
- enable dropped during BODY:
  - The packet completes normally.
  - The block then stays in IDLE with out_valid=0 until enable returns.
- MAX_PKTS=2:
  - Exactly 8 flits are accepted, then DONE.
  - pkt_count=2, busy=0, and out_valid stays 0 with enable=1 for 50 cycles.
- Reset asserted during BODY:
  - out_valid and pkt_count go to 0 without waiting for a clock edge.
  - After release, the first head is 0x85 again.
- Edge parameters, PKT_FLITS=1 and GAP=0:
  - Every flit is a head with out_last=1.
  - Period is 2 cycles; destinations follow the LFSR sequence 0x05, 0x02, ...
